// File: rtl/ysyx_24110015_exec_seq_pkg.sv
// Shared definitions for the multi-cycle execute sequencer: state encoding,
// default wait-state timeout and a state classification helper.
package ysyx_24110015_exec_seq_pkg;

  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_FWAIT  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_MWAIT  = 3'd5,
    S_WB     = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  // States that wait on a memory handshake and are therefore watched by the timer.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_FWAIT) || (s == S_MEM) || (s == S_MWAIT);
  endfunction

endpackage

// File: rtl/ysyx_24110015_wait_timer.sv
// Counts cycles spent in one wait state; expired flags the TIMEOUT-th cycle
// so the sequencer can bail out on that same cycle if no handshake occurs.
module ysyx_24110015_wait_timer
  import ysyx_24110015_exec_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            W     = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]  LIMIT = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of earlier cycles in this state; saturates at LIMIT.
  assign expired = enable && (cnt_q >= LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ysyx_24110015_exec_seq.sv
// Multi-cycle instruction sequencer: walks fetch/decode/execute/memory/writeback,
// raises the datapath strobes, counts cycles and retired instructions.
module ysyx_24110015_exec_seq
  import ysyx_24110015_exec_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  output logic             imem_rsp_ready,
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  input  logic             dmem_rsp_valid,
  output logic             dmem_rsp_ready,
  input  logic             is_mem,
  input  logic             rf_wen_dec,
  input  logic             ebreak,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic             halt,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret,
  output state_t           dbg_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             tmr_clear, tmr_enable, tmr_expired;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // valid is held until accepted and ready is only raised in the consuming wait state,
  // so a response can never be taken in the cycle its request is accepted.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    cycle_d   = (state_q == S_HALT) ? cycle_q : cycle_q + CNT_ONE;
    instret_d = (state_q == S_WB) ? instret_q + CNT_ONE : instret_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem_req_ready) state_d = S_FWAIT;
        else if (tmr_expired) begin state_d = S_HALT; err_d = 1'b1; end
      end
      S_FWAIT: begin
        if (imem_rsp_valid) state_d = S_DECODE;
        else if (tmr_expired) begin state_d = S_HALT; err_d = 1'b1; end
      end
      S_DECODE: state_d = ebreak ? S_HALT : S_EXEC;
      S_EXEC:   state_d = is_mem ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_req_ready) state_d = S_MWAIT;
        else if (tmr_expired) begin state_d = S_HALT; err_d = 1'b1; end
      end
      S_MWAIT: begin
        if (dmem_rsp_valid) state_d = S_WB;
        else if (tmr_expired) begin state_d = S_HALT; err_d = 1'b1; end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Any state change restarts the timer, so each wait state is timed from its entry.
  assign tmr_clear  = (state_d != state_q);
  assign tmr_enable = is_wait_state(state_q);

  ysyx_24110015_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      err_q     <= 1'b0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  // IR is loaded on every FWAIT cycle; the last load is the one at the response handshake.
  assign imem_req_valid = (state_q == S_FETCH);
  assign imem_rsp_ready = (state_q == S_FWAIT);
  assign ir_we          = (state_q == S_FWAIT);
  assign dmem_req_valid = (state_q == S_MEM);
  assign dmem_rsp_ready = (state_q == S_MWAIT);
  assign pc_we          = (state_q == S_WB);
  assign rf_we          = (state_q == S_WB) && rf_wen_dec;
  assign halt           = (state_q == S_HALT);
  assign err            = err_q;
  assign cycle_cnt      = cycle_q;
  assign instret        = instret_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/ysyx_24110015_exec_seq.md
YSYX_24110015_EXEC_SEQ -- requirements
Module: ysyx_24110015_exec_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles spent in one wait state before an error halt.
REQ-002 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port imem_req_valid, output, 1: instruction fetch request.
REQ-006 SHALL have port imem_req_ready, input, 1: instruction memory accepts the fetch request.
REQ-007 SHALL have port imem_rsp_valid, input, 1: instruction word available.
REQ-008 SHALL have port imem_rsp_ready, output, 1: sequencer accepts the instruction word.
REQ-009 SHALL have port dmem_req_valid, output, 1: data memory request (load or store).
REQ-010 SHALL have port dmem_req_ready, input, 1: data memory accepts the request.
REQ-011 SHALL have port dmem_rsp_valid, input, 1: data memory response or write acknowledge.
REQ-012 SHALL have port dmem_rsp_ready, output, 1: sequencer accepts the data response.
REQ-013 SHALL have port is_mem, input, 1: decoded instruction accesses data memory; sampled in EXEC.
REQ-014 SHALL have port rf_wen_dec, input, 1: decoded register write enable; sampled in WB.
REQ-015 SHALL have port ebreak, input, 1: decoded ebreak; sampled in DECODE.
REQ-016 SHALL have port ir_we, output, 1: instruction register load strobe.
REQ-017 SHALL have port pc_we, output, 1: PC register load strobe; PC loads the executor's pc_next.
REQ-018 SHALL have port rf_we, output, 1: register file write strobe.
REQ-019 SHALL have port halt, output, 1: sticky halt indication.
REQ-020 SHALL have port err, output, 1: sticky timeout error indication.
REQ-021 SHALL have port cycle_cnt, output, CNT_W: cycles elapsed since reset.
REQ-022 SHALL have port instret, output, CNT_W: count of retired instructions.

Function
REQ-023 SHALL implement a Moore FSM with states FETCH, FWAIT, DECODE, EXEC, MEM, MWAIT, WB and HALT; every strobe and valid/ready output SHALL be decoded from the current state only.
REQ-024 FETCH: imem_req_valid SHALL be 1; the FSM SHALL go to FWAIT on imem_req_ready=1 and otherwise stay in FETCH with valid held.
REQ-025 FWAIT: imem_rsp_ready SHALL be 1; on imem_rsp_valid=1, ir_we SHALL be 1 for that cycle and the FSM SHALL go to DECODE.
REQ-026 DECODE (1 cycle): if ebreak=1, the FSM SHALL go to HALT, with no pc_we and no instret increment; otherwise it SHALL go to EXEC.
REQ-027 EXEC (1 cycle): the FSM SHALL go to MEM if is_mem=1, else to WB.
REQ-028 MEM: dmem_req_valid SHALL be 1; the FSM SHALL go to MWAIT on dmem_req_ready=1.
REQ-029 MWAIT: dmem_rsp_ready SHALL be 1; the FSM SHALL go to WB on dmem_rsp_valid=1.
REQ-030 WB (1 cycle): pc_we SHALL be 1, rf_we SHALL equal rf_wen_dec, instret SHALL increment, and the FSM SHALL go to FETCH.
REQ-031 A response arriving in the same cycle as its request is accepted SHALL be ignored; responses are consumed only in FWAIT or MWAIT.
REQ-032 A wait timer SHALL clear on entry to FETCH, FWAIT, MEM or MWAIT and count each cycle spent there; when it reaches TIMEOUT without a handshake, the FSM SHALL go to HALT with err=1.
REQ-033 HALT SHALL be absorbing until reset, with halt=1 and all strobes and valids 0.
REQ-034 cycle_cnt SHALL increment every cycle outside HALT; cycle_cnt and instret SHALL wrap modulo 2^CNT_W.
REQ-035 Worst-case latency with zero-wait memories: non-memory instruction 5 cycles; memory instruction 7 cycles.

Reset
REQ-036 On rst=1 the block SHALL immediately enter FETCH with cycle_cnt=0, instret=0, halt=0, err=0, timer=0, and all strobes 0 except imem_req_valid=1 after release.
REQ-037 Reset mid-transaction SHALL abandon the transaction silently; any later stray response SHALL be ignored because rsp_ready is 0 outside the wait states.

Structure
REQ-038 State encoding and the TIMEOUT default SHALL live in the shared macros/package file.
REQ-039 The wait timer SHALL be a sub-module, ysyx_24110015_wait_timer, with ports clear, enable and expired.

Verification
REQ-040 Zero-wait memories, a non-memory instruction with rf_wen_dec=1: pc_we and rf_we are 1 in cycle 5 and instret=1.
REQ-041 is_mem=1, dmem_req_ready delayed 3 cycles and dmem_rsp_valid delayed 2 cycles: pc_we occurs in cycle 12 and dmem_req_valid stays high through the stall.
REQ-042 ebreak=1 in DECODE: halt=1 from the next cycle, pc_we never 1, cycle_cnt frozen, instret unchanged.
REQ-043 TIMEOUT=4 and imem_rsp_valid held 0: after 4 FWAIT cycles, halt=1 and err=1.
REQ-044 rst pulsed while in MWAIT, then dmem_rsp_valid=1: FSM in FETCH, counters 0, and the response is not consumed.
REQ-045 CNT_W=4 with 16 retired instructions: instret wraps to 0.
